countdown_bcd_display: RTL and testbench

Downstream display stage for the lab countdown counter: it takes the counter's N-bit binary `value` and drives DIGITS active-low seven-segment digits in decimal. Binary-to-BCD conversion is sequential (shift-and-add-3, one bit per clock), so no wide combinational divider is needed. A new conversion starts automatically whenever the input differs from the last converted value. Leading zeros are blanked.

---
 rtl/countdown_bcd_display.sv | 137 +++++++++++++
 tb/tb_countdown_bcd_display.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/countdown_bcd_display.sv
// countdown_bcd_display
//   Turns the countdown stage's binary value into DIGITS active-low
//   seven-segment digits. Binary-to-BCD runs sequentially (shift-and-add-3,
//   one bit per clock) and restarts on its own whenever the input differs
//   from the last converted value. Leading zeros are blanked.
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   value  : N-bit unsigned count, synchronous to clk
//   seg    : digit d on seg[7d+6:7d] (d=0 least significant), bit0=a..bit6=g, 0=lit
//   busy   : high while a conversion is in flight (N+1 cycles)
//   zero   : high when the displayed value is 0
module countdown_bcd_display #(
    parameter int N      = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          value,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  zero
);

    localparam longint MAXV = (longint'(1) << N) - 1;
    localparam longint TENP = longint'(10) ** DIGITS;

    generate
        if (N < 1 || TENP <= MAXV) begin : g_param_err
            $error("countdown_bcd_display: need N>=1 and 10**DIGITS > 2**N-1");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]            r_state;
    logic [N-1:0]          r_shown;
    logic                  r_valid;
    logic [N-1:0]          r_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [CW-1:0]         r_cnt;
    logic [7*DIGITS-1:0]   r_seg;
    logic                  r_zero;

    logic [4*DIGITS-1:0]   w_adj;
    logic [7*DIGITS-1:0]   w_seg;
    logic                  w_lit;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 7'h40;
            4'd1:    enc7 = 7'h79;
            4'd2:    enc7 = 7'h24;
            4'd3:    enc7 = 7'h30;
            4'd4:    enc7 = 7'h19;
            4'd5:    enc7 = 7'h12;
            4'd6:    enc7 = 7'h02;
            4'd7:    enc7 = 7'h78;
            4'd8:    enc7 = 7'h00;
            4'd9:    enc7 = 7'h10;
            default: enc7 = 7'h7F;
        endcase
    endfunction

    // Add-3 correction: any digit >=5 would exceed 9 after the next doubling.
    always_comb begin
        w_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            else
                w_adj[4*d +: 4] = r_bcd[4*d +: 4];
        end
    end

    // Walk from the most significant digit down; a digit is lit once it or
    // any digit above it is non-zero. Digit 0 is always lit.
    always_comb begin
        w_seg = '1;
        w_lit = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            w_lit = w_lit | (r_bcd[4*d +: 4] != 4'd0) | (d == 0);
            if (w_lit)
                w_seg[7*d +: 7] = enc7(r_bcd[4*d +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shown <= '0;
            r_valid <= 1'b0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_seg   <= '1;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_valid || value != r_shown) begin
                        r_bin   <= value;
                        r_shown <= value;
                        r_valid <= 1'b1;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // {BCD, bin} << 1 after the add-3 correction
                    r_bcd <= (w_adj << 1) | (4*DIGITS)'(r_bin[N-1]);
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_seg   <= w_seg;
                    r_zero  <= (r_bcd == '0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign seg  = r_seg;
    assign zero = r_zero;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_countdown_bcd_display.sv
module tb_countdown_bcd_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  value;
    logic [20:0] seg;
    logic        busy;
    logic        zero;

    int checks = 0;
    int errors = 0;

    countdown_bcd_display #(.N(7), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .busy  (busy),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    // Waits for the next conversion to run to completion. lat = edge index
    // (1 = first edge after the call) at which busy was first seen high,
    // cyc = number of sampled cycles busy stayed high. Bounded at 100 edges.
    task automatic wait_conv(output int lat, output int cyc);
        lat = 0;
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                if (cyc == 0) lat = i;
                cyc++;
            end else if (cyc > 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset;
        int lat, cyc;
        reset = 1'b1;
        value = 7'd127;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (seg !== 21'h1FFFFF) begin errors++; $display("FAIL reset_seg got %h want %h", seg, 21'h1FFFFF); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
        @(negedge clk) reset = 1'b0;
        wait_conv(lat, cyc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL v127_capture got edge %0d want 1", lat); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL v127_busy got %0d want 8", cyc); end
        checks++; if (seg !== {7'h79, 7'h24, 7'h78}) begin errors++; $display("FAIL v127_seg got %h want %h", seg, {7'h79, 7'h24, 7'h78}); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL v127_zero got %b want 0", zero); end
    endtask

    task automatic test_blank_leading;
        int lat, cyc;
        @(negedge clk) begin reset = 1'b1; value = 7'd5; end
        @(negedge clk) reset = 1'b0;
        wait_conv(lat, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL v5_busy got %0d want 8", cyc); end
        checks++; if (seg !== {7'h7F, 7'h7F, 7'h12}) begin errors++; $display("FAIL v5_seg got %h want %h", seg, {7'h7F, 7'h7F, 7'h12}); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL v5_zero got %b want 0", zero); end
    endtask

    task automatic test_inner_zero;
        int lat, cyc;
        @(negedge clk) value = 7'd100;
        wait_conv(lat, cyc);
        checks++; if (seg !== {7'h79, 7'h40, 7'h40}) begin errors++; $display("FAIL v100_seg got %h want %h", seg, {7'h79, 7'h40, 7'h40}); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL v100_zero got %b want 0", zero); end
        @(negedge clk) value = 7'd0;
        wait_conv(lat, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL v0_busy got %0d want 8", cyc); end
        checks++; if (seg !== {7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL v0_seg got %h want %h", seg, {7'h7F, 7'h7F, 7'h40}); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL v0_zero got %b want 1", zero); end
        @(negedge clk) value = 7'd10;
        wait_conv(lat, cyc);
        checks++; if (seg !== {7'h7F, 7'h79, 7'h40}) begin errors++; $display("FAIL v10_seg got %h want %h", seg, {7'h7F, 7'h79, 7'h40}); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL v10_zero got %b want 0", zero); end
    endtask

    task automatic test_stable;
        int lat, cyc, busy_cnt;
        @(negedge clk) value = 7'd42;
        wait_conv(lat, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL v42_busy got %0d want 8", cyc); end
        busy_cnt = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL stable_busy got %0d busy cycles want 0", busy_cnt); end
        checks++; if (seg !== {7'h7F, 7'h19, 7'h24}) begin errors++; $display("FAIL v42_seg got %h want %h", seg, {7'h7F, 7'h19, 7'h24}); end
    endtask

    task automatic test_back_to_back;
        int lat, cyc, n;
        @(negedge clk) value = 7'd127;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_capture got busy %b want 1", busy); end
        @(posedge clk);
        @(negedge clk) value = 7'd126;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_first_done got busy %b want 0", busy); end
        checks++; if (seg !== {7'h79, 7'h24, 7'h78}) begin errors++; $display("FAIL b2b_first_seg got %h want %h", seg, {7'h79, 7'h24, 7'h78}); end
        wait_conv(lat, cyc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_recapture got edge %0d want 1", lat); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL b2b_busy got %0d want 8", cyc); end
        checks++; if (seg !== {7'h79, 7'h24, 7'h02}) begin errors++; $display("FAIL b2b_second_seg got %h want %h", seg, {7'h79, 7'h24, 7'h02}); end
    endtask

    task automatic test_reset_mid;
        int lat, cyc;
        @(negedge clk) value = 7'd55;
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        checks++; if (seg !== 21'h1FFFFF) begin errors++; $display("FAIL mid_reset_seg got %h want %h", seg, 21'h1FFFFF); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL mid_reset_zero got %b want 0", zero); end
        @(negedge clk) reset = 1'b0;
        wait_conv(lat, cyc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL v55_capture got edge %0d want 1", lat); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL v55_busy got %0d want 8", cyc); end
        checks++; if (seg !== {7'h7F, 7'h12, 7'h12}) begin errors++; $display("FAIL v55_seg got %h want %h", seg, {7'h7F, 7'h12, 7'h12}); end
    endtask

    initial begin
        test_reset();
        test_blank_leading();
        test_inner_zero();
        test_stable();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
